// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding a UART transmitter through a
// transmit/busy handshake with a timeout on the busy response.
// Optional feature macro: UART_TXQ_DROP_CNT_EN adds a saturating 16-bit
// drop_cnt output counting rejected writes and handshake timeouts.
module uart_tx_queue #(
    parameter int DEPTH      = 16,
    parameter int HS_TIMEOUT = 65535
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     transmit,
    output logic [7:0]               TX_Data,
    input  logic                     busy,
    output logic                     hs_err
`ifdef UART_TXQ_DROP_CNT_EN
    ,
    output logic [15:0]              drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(HS_TIMEOUT + 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] TO_LAST  = CW'(HS_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic            full_q, empty_q;
    logic [7:0]      tx_data_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_meta_q, busy_sync_q;
    logic            push_s, pop_s, timeout_s;

    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = level_q;
    assign TX_Data = tx_data_q;

    // Two-flop synchronizer for the possibly asynchronous busy input
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_meta_q <= 1'b0;
            busy_sync_q <= 1'b0;
        end else begin
            busy_meta_q <= busy;
            busy_sync_q <= busy_meta_q;
        end
    end

    // Push/pop qualification and next pointer/level values
    always_comb begin
        push_s   = wr_en && !full_q;
        pop_s    = (state_q == LOAD);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // FIFO storage; reset only clears pointers, so stale bytes are unreachable
    always_ff @(posedge clk) begin
        if (reset && push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // FIFO pointers, level and flags registered from the same next level
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= (level_d == LVL_FULL);
            empty_q  <= (level_d == '0);
        end
    end

    // Head byte captured on pop and held until the next pop
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_data_q <= 8'h00;
        end else if (pop_s) begin
            tx_data_q <= mem_q[rd_ptr_q];
        end else begin
            tx_data_q <= tx_data_q;
        end
    end

    // Timeout detect: last permitted WAIT_HI cycle with busy still low
    always_comb begin
        if (state_q == WAIT_HI && !busy_sync_q && cnt_q == TO_LAST) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Handshake counter: cleared while loading, counts WAIT_HI cycles
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == LOAD) begin
            cnt_d = '0;
        end else if (state_q == WAIT_HI && !timeout_s && !busy_sync_q) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!empty_q && !busy_sync_q) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD:    state_d = WAIT_HI;
            WAIT_HI: begin
                if (busy_sync_q) begin
                    state_d = WAIT_LO;
                end else if (timeout_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_LO: begin
                if (!busy_sync_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_LO;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs decoded from registered state only
    always_comb begin
        transmit = 1'b0;
        hs_err   = 1'b0;
        if (state_q == WAIT_HI) begin
            transmit = 1'b1;
            hs_err   = timeout_s;
        end else begin
            transmit = 1'b0;
            hs_err   = 1'b0;
        end
    end

`ifdef UART_TXQ_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [16:0] drop_sum_s;

    assign drop_cnt = drop_cnt_q;

    // Saturating sum of rejected writes and handshake timeouts
    always_comb begin
        drop_sum_s = {1'b0, drop_cnt_q} + {16'h0000, (wr_en && full_q)}
                   + {16'h0000, timeout_s};
        if (drop_sum_s[16]) begin
            drop_cnt_d = 16'hFFFF;
        end else begin
            drop_cnt_d = drop_sum_s[15:0];
        end
    end

    // Drop counter register
    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt_q <= 16'h0000;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end
`endif

endmodule
